// File: rtl/mem_port_arbiter.sv
// Arbitrates the shared physical memory port between data access and instruction fetch,
// and steers fixed-latency load returns back to whichever requester issued them.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_W
`define REG_W 64
`endif

package mem_port_arbiter_pkg;
  typedef enum logic [1:0] {
    BMD_08 = 2'd0,
    BMD_16 = 2'd1,
    BMD_32 = 2'd2,
    BMD_64 = 2'd3
  } bmd_t;
endpackage

module mem_port_arbiter
  import mem_port_arbiter_pkg::*;
#(
  parameter int LOAD_LATENCY = 1,
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               d_valid,
  output logic               d_ready,
  input  logic [`ADDR_W-1:0] d_addr,
  input  logic               d_we,
  input  bmd_t               d_bmd,
  input  logic [`REG_W-1:0]  d_st_data,
  output logic               d_rvalid,
  output logic [`REG_W-1:0]  d_rdata,
  input  logic               f_valid,
  output logic               f_ready,
  input  logic [`ADDR_W-1:0] f_addr,
  output logic               f_rvalid,
  output logic [`REG_W-1:0]  f_rdata,
  input  logic               flush,
  input  logic               mem_stall,
  output logic               mem_valid,
  output logic [`ADDR_W-1:0] mem_addr,
  output logic               mem_we,
  output bmd_t               mem_bmd,
  output logic [`REG_W-1:0]  mem_st_data,
  input  logic [`REG_W-1:0]  mem_rdata
);

  // One extra stage covers the registered request cycle before the memory latency starts.
  localparam int         PIPE_D     = LOAD_LATENCY + 1;
  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  logic [3:0]        r_starveCnt;
  logic [PIPE_D-1:0] r_pipeLive;
  logic [PIPE_D-1:0] r_pipeOwner;

  logic              w_starved;
  logic              w_grantD;
  logic              w_grantF;
  logic              w_pushLive;
  logic [PIPE_D-1:0] w_keepLive;

  always_comb begin
    w_starved = (r_starveCnt == STARVE_MAX);
    w_grantD  = 1'b0;
    w_grantF  = 1'b0;
    if (!rst && !mem_stall) begin
      if (w_starved && f_valid) w_grantF = 1'b1;
      else if (d_valid)         w_grantD = 1'b1;
      else if (f_valid)         w_grantF = 1'b1;
    end
    // A fetch granted during a flush still occupies a slot but must never return.
    w_pushLive = (w_grantD && !d_we) || (w_grantF && !flush);
    w_keepLive = r_pipeLive & ~(r_pipeOwner & {PIPE_D{flush}});
  end

  assign d_ready  = w_grantD;
  assign f_ready  = w_grantF;
  assign d_rvalid = w_keepLive[PIPE_D-1] & ~r_pipeOwner[PIPE_D-1];
  assign f_rvalid = w_keepLive[PIPE_D-1] &  r_pipeOwner[PIPE_D-1];
  assign d_rdata  = mem_rdata;
  assign f_rdata  = mem_rdata;

  // Stalled cycles count as denials; the count saturates so fetch keeps its claim.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_starveCnt <= 4'd0;
    end else if (!f_valid || w_grantF) begin
      r_starveCnt <= 4'd0;
    end else if (!w_starved) begin
      r_starveCnt <= r_starveCnt + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid   <= 1'b0;
      mem_addr    <= '0;
      mem_we      <= 1'b0;
      mem_bmd     <= BMD_08;
      mem_st_data <= '0;
    end else begin
      mem_valid <= w_grantD | w_grantF;
      if (w_grantD) begin
        mem_addr    <= d_addr;
        mem_we      <= d_we;
        mem_bmd     <= d_bmd;
        mem_st_data <= d_st_data;
      end else if (w_grantF) begin
        mem_addr    <= f_addr;
        mem_we      <= 1'b0;
        mem_bmd     <= BMD_64;
        mem_st_data <= '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pipeLive  <= '0;
      r_pipeOwner <= '0;
    end else begin
      r_pipeLive  <= {w_keepLive[PIPE_D-2:0], w_pushLive};
      r_pipeOwner <= {r_pipeOwner[PIPE_D-2:0], w_grantF};
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a small reference model predicts grants, shared-port
// requests and load returns, queueing each expectation until the cycle it is due.
`ifndef ADDR_W
`define ADDR_W 32
`endif
`ifndef REG_W
`define REG_W 64
`endif

module tb_mem_port_arbiter;
  import mem_port_arbiter_pkg::*;

  localparam int LOAD_LATENCY = 1;
  localparam int STARVE_LIMIT = 4;

  typedef struct {
    int                 due;
    logic [`ADDR_W-1:0] addr;
    logic               we;
    bmd_t               bmd;
    logic [`REG_W-1:0]  st;
  } memExp_t;

  typedef struct {
    int   due;
    logic live;
    logic owner;
  } retExp_t;

  logic               clk = 1'b0;
  logic               rst;
  logic               d_valid, d_ready, d_we, d_rvalid;
  logic [`ADDR_W-1:0] d_addr;
  bmd_t               d_bmd;
  logic [`REG_W-1:0]  d_st_data, d_rdata;
  logic               f_valid, f_ready, f_rvalid;
  logic [`ADDR_W-1:0] f_addr;
  logic [`REG_W-1:0]  f_rdata;
  logic               flush, mem_stall, mem_valid, mem_we;
  logic [`ADDR_W-1:0] mem_addr;
  bmd_t               mem_bmd;
  logic [`REG_W-1:0]  mem_st_data, mem_rdata;

  int      cyc = 0;
  int      vectors = 0;
  int      errors = 0;
  int      mStarve = 0;
  bit      afterReset = 1'b0;
  memExp_t memQ[$];
  retExp_t retQ[$];

  mem_port_arbiter #(.LOAD_LATENCY(LOAD_LATENCY), .STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk(clk), .rst(rst),
    .d_valid(d_valid), .d_ready(d_ready), .d_addr(d_addr), .d_we(d_we), .d_bmd(d_bmd),
    .d_st_data(d_st_data), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .f_valid(f_valid), .f_ready(f_ready), .f_addr(f_addr), .f_rvalid(f_rvalid),
    .f_rdata(f_rdata), .flush(flush), .mem_stall(mem_stall),
    .mem_valid(mem_valid), .mem_addr(mem_addr), .mem_we(mem_we), .mem_bmd(mem_bmd),
    .mem_st_data(mem_st_data), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mem_rdata = 64'hDEAD + (64'(cyc) << 16);

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    vectors++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s @cycle %0d: got 0x%0h, expected 0x%0h", tag, cyc, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic iRst, input logic iDv, input logic iDwe, input bmd_t iBmd,
                               input logic [`ADDR_W-1:0] iDa, input logic [`REG_W-1:0] iSt,
                               input logic iFv, input logic [`ADDR_W-1:0] iFa,
                               input logic iFlush, input logic iStall);
    rst = iRst; d_valid = iDv; d_we = iDwe; d_bmd = iBmd; d_addr = iDa; d_st_data = iSt;
    f_valid = iFv; f_addr = iFa; flush = iFlush; mem_stall = iStall;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, BMD_08, '0, '0, 0, '0, 0, 0);
  endtask

  // Reference model and scoreboard, evaluated mid-cycle once inputs have settled.
  always @(negedge clk) begin
    logic expD, expF, gD, gF;
    if (rst) begin
      checkOutput("d_ready_in_reset", 64'(d_ready), 64'd0);
      checkOutput("f_ready_in_reset", 64'(f_ready), 64'd0);
      memQ.delete();
      retQ.delete();
      mStarve    = 0;
      afterReset = 1'b1;
    end else begin
      if (flush)
        foreach (retQ[i]) if (retQ[i].owner) retQ[i].live = 1'b0;

      if (memQ.size() > 0 && memQ[0].due == cyc) begin
        checkOutput("mem_valid", 64'(mem_valid), 64'd1);
        checkOutput("mem_addr", 64'(mem_addr), 64'(memQ[0].addr));
        checkOutput("mem_we", 64'(mem_we), 64'(memQ[0].we));
        checkOutput("mem_bmd", 64'(mem_bmd), 64'(memQ[0].bmd));
        checkOutput("mem_st_data", 64'(mem_st_data), 64'(memQ[0].st));
        void'(memQ.pop_front());
      end else begin
        checkOutput("mem_valid_idle", 64'(mem_valid), 64'd0);
        if (afterReset) begin
          checkOutput("mem_addr_rst", 64'(mem_addr), 64'd0);
          checkOutput("mem_we_rst", 64'(mem_we), 64'd0);
          checkOutput("mem_bmd_rst", 64'(mem_bmd), 64'(BMD_08));
          checkOutput("mem_st_data_rst", 64'(mem_st_data), 64'd0);
        end
      end
      afterReset = 1'b0;

      expD = 1'b0;
      expF = 1'b0;
      if (retQ.size() > 0 && retQ[0].due == cyc) begin
        if (retQ[0].live) begin
          if (retQ[0].owner) expF = 1'b1;
          else               expD = 1'b1;
        end
        void'(retQ.pop_front());
      end
      checkOutput("d_rvalid", 64'(d_rvalid), 64'(expD));
      checkOutput("f_rvalid", 64'(f_rvalid), 64'(expF));
      if (expD) checkOutput("d_rdata", d_rdata, mem_rdata);
      if (expF) checkOutput("f_rdata", f_rdata, mem_rdata);

      gD = 1'b0;
      gF = 1'b0;
      if (!mem_stall) begin
        if (mStarve == STARVE_LIMIT && f_valid) gF = 1'b1;
        else if (d_valid)                       gD = 1'b1;
        else if (f_valid)                       gF = 1'b1;
      end
      checkOutput("d_ready", 64'(d_ready), 64'(gD));
      checkOutput("f_ready", 64'(f_ready), 64'(gF));

      if (gD) begin
        memQ.push_back('{due: cyc + 1, addr: d_addr, we: d_we, bmd: d_bmd, st: d_st_data});
        retQ.push_back('{due: cyc + 1 + LOAD_LATENCY, live: !d_we, owner: 1'b0});
      end
      if (gF) begin
        memQ.push_back('{due: cyc + 1, addr: f_addr, we: 1'b0, bmd: BMD_64, st: '0});
        retQ.push_back('{due: cyc + 1 + LOAD_LATENCY, live: !flush, owner: 1'b1});
      end

      if (!f_valid || gF)             mStarve = 0;
      else if (mStarve < STARVE_LIMIT) mStarve = mStarve + 1;
    end
  end

  initial begin
    // Reset held with both requesters asking
    applyStimulus(1, 1, 0, BMD_64, 32'h40, '0, 1, 32'h80, 0, 0);
    applyStimulus(1, 1, 0, BMD_64, 32'h40, '0, 1, 32'h80, 0, 0);
    idle(3);

    // Priority on the first cycle, then starvation forces one fetch grant
    for (int i = 0; i < 7; i++)
      applyStimulus(0, 1, 0, BMD_64, 32'h100 + 32'(8 * i), '0, 1, 32'h400 + 32'(4 * i), 0, 0);
    idle(3);

    // Store never returns data
    applyStimulus(0, 1, 1, BMD_32, 32'h208, 64'h1234, 0, '0, 0, 0);
    idle(3);

    // Flush kills fetch returns in flight and the fetch granted alongside it
    applyStimulus(0, 0, 0, BMD_08, '0, '0, 1, 32'h800, 0, 0);
    applyStimulus(0, 0, 0, BMD_08, '0, '0, 1, 32'h804, 1, 0);
    applyStimulus(0, 1, 0, BMD_16, 32'h300, '0, 0, '0, 0, 0);
    idle(3);

    // Flush landing on the same cycle the fetch return reaches the head
    applyStimulus(0, 0, 0, BMD_08, '0, '0, 1, 32'h900, 0, 0);
    applyStimulus(0, 0, 0, BMD_08, '0, '0, 0, '0, 0, 0);
    applyStimulus(0, 0, 0, BMD_08, '0, '0, 0, '0, 1, 0);
    idle(2);

    // Stall blocks grants but accumulates fetch starvation
    for (int i = 0; i < 3; i++) applyStimulus(0, 0, 0, BMD_08, '0, '0, 1, 32'hA00, 0, 1);
    applyStimulus(0, 0, 0, BMD_08, '0, '0, 1, 32'hA00, 0, 0);
    idle(2);

    // Mixed traffic, including stalls and occasional flushes
    for (int i = 0; i < 60; i++)
      applyStimulus(0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), bmd_t'($urandom_range(0, 3)),
                    32'($urandom), 64'({$urandom, $urandom}), 1'($urandom_range(0, 2) != 0),
                    32'($urandom) & 32'hFFFF_FFFC, ($urandom_range(0, 9) == 0),
                    ($urandom_range(0, 5) == 0));

    // Reset mid-operation drops in-flight returns
    applyStimulus(0, 1, 0, BMD_64, 32'hC00, '0, 1, 32'hD00, 0, 0);
    applyStimulus(0, 0, 0, BMD_08, '0, '0, 1, 32'hD04, 0, 0);
    applyStimulus(1, 1, 0, BMD_64, 32'hC08, '0, 1, 32'hD08, 0, 0);
    idle(LOAD_LATENCY + 3);
    applyStimulus(0, 1, 0, BMD_64, 32'hE00, '0, 0, '0, 0, 0);
    idle(4);

    @(negedge clk);
    #1;
    checkOutput("scoreboard_drained", 64'(memQ.size() + retQ.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
